retro_accum_alu: RTL and testbench
==================================

// Module: retro_accum_alu
// PURPOSE
//   Parametrised successor of the tile's combinational ui_in+uio_in adder: a registered
//   multi-channel add/accumulate unit with selectable wrap/saturate modes, valid/ready
//   handshakes on both sides, and per-channel sticky overflow status. Sits between the
//   tile pin-mux and the SoC register bus; one operation is accepted per cycle.
// PARAMETERS
//   DATA_W   8   operand/result/accumulator width (>=2)
//   NUM_CH   4   number of independent accumulator channels (>=1, need not be 2^n)
//   CH_W     $clog2(NUM_CH) (min 1)   channel-select width; derived, do not override
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        synchronous reset, active-high
//   in_valid   in   1        request valid
//   in_ready   out  1        unit can accept request this cycle
//   in_op      in   2        00 ADD, 01 ADD_SAT, 10 ACC, 11 LOAD
//   in_ch      in   CH_W     target channel (ACC/LOAD); ignored for ADD/ADD_SAT
//   in_a       in   DATA_W   operand A
//   in_b       in   DATA_W   operand B (ignored by ACC/LOAD)
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer takes result
//   out_data   out  DATA_W   result
//   out_ovf    out  1        carry-out / saturation of this operation
//   out_err    out  1        in_ch >= NUM_CH on an ACC/LOAD
//   sticky_ovf out  NUM_CH   per-channel overflow history (ACC ops only)
//   clr_sticky in   1        one-cycle pulse: clear all sticky_ovf bits
// BEHAVIOUR
//   - Reset: out_valid=0, out_data=0, out_ovf=0, out_err=0, all accumulators=0,
//     sticky_ovf=0. Reset mid-operation discards any held result; in_ready=1 next cycle.
//   - Handshake: accept when in_valid&&in_ready; in_ready = !out_valid || out_ready
//     (full throughput, 1-cycle latency, no combinational in_valid->out_valid path).
//     out_data/out_ovf/out_err stable while out_valid && !out_ready.
//   - Arithmetic on accept, unsigned, DATA_W+1 bit internal sum, c = sum[DATA_W]:
//     ADD:     out_data = sum[DATA_W-1:0], out_ovf = c.
//     ADD_SAT: out_data = c ? all-ones : sum[DATA_W-1:0], out_ovf = c.
//     ACC:     acc[ch] <= acc[ch]+in_a (wrap); out_data = new acc; out_ovf = carry;
//              carry sets sticky_ovf[ch].
//     LOAD:    acc[ch] <= in_a; out_data = previous acc[ch]; out_ovf = 0.
//   - Accumulator updates at the accept edge, so back-to-back ACC to same channel
//     chain correctly with no bubble (second op sees first op's result).
//   - in_ch >= NUM_CH on ACC/LOAD: accepted, out_data=0, out_ovf=0, out_err=1,
//     no accumulator or sticky change. out_err=0 for all other accepts.
//   - clr_sticky and a same-cycle sticky set on channel k: set wins for k, others clear.
//   - clr_sticky acts regardless of handshake state; no other side effects.
//   - No internal FSM beyond the output-holding register (states EMPTY/FULL =
//     out_valid 0/1): EMPTY->FULL on accept; FULL->EMPTY on out_ready && !accept;
//     FULL->FULL on out_ready && accept (result replaced).
// STRUCTURE
//   - Package retro_alu_pkg: op encodings (OP_ADD, OP_ADD_SAT, OP_ACC, OP_LOAD),
//     op typedef, DATA_W default constant.
//   - One sub-module retro_sat_adder (combinational): a, b, sat_en -> sum, carry.
//     Shared by ADD/ADD_SAT/ACC paths; accumulator array and output register in top.
// TESTING
//   - Reset with out_valid=1 pending -> out_valid=0, accs=0, sticky_ovf=0 next cycle.
//   - ADD 8'hF0+8'h20 -> out_data=8'h10, out_ovf=1; ADD_SAT same -> 8'hFF, out_ovf=1;
//     ADD_SAT 8'h10+8'h20 -> 8'h30, out_ovf=0.
//   - ACC ch2 a=8'h80 three times back-to-back, out_ready=1 -> 80, 00(ovf=1), 80;
//     sticky_ovf=4'b0100; LOAD ch2 a=8'h05 -> out_data=8'h80, acc[2]=05.
//   - out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data held; release
//     -> no lost or duplicated result, 1 result/cycle thereafter.
//   - NUM_CH=3: ACC with in_ch=3 -> out_err=1, out_data=0, accumulators unchanged.
//   - clr_sticky same cycle as ACC overflow on ch1 -> sticky_ovf=4'b0010 after.

Source files
------------

// File: rtl/retro_alu_pkg.sv
// Shared definitions for the retro accumulate ALU: op encodings and width default.
package retro_alu_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_ADD_SAT = 2'b01,
        OP_ACC     = 2'b10,
        OP_LOAD    = 2'b11
    } op_e;

endpackage

// File: rtl/retro_sat_adder.sv
// Unsigned adder with carry-out and optional clamp-to-all-ones on carry.
module retro_sat_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sat_en_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);

    logic [W:0] sum_full;

    // One extra bit captures the carry; saturation reuses it as the clamp select.
    always_comb begin
        sum_full = {1'b0, a_i} + {1'b0, b_i};
        carry_o  = sum_full[W];
        sum_o    = (sat_en_i && sum_full[W]) ? {W{1'b1}} : sum_full[W-1:0];
    end

endmodule

// File: rtl/retro_accum_alu.sv
// Registered multi-channel add/accumulate unit with valid/ready on both sides
// and per-channel sticky overflow flags.
module retro_accum_alu
    import retro_alu_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  NUM_CH = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf,
    output logic              out_err,
    output logic [NUM_CH-1:0] sticky_ovf,
    input  logic              clr_sticky
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    op_e                           op;
    logic                          accept;
    logic                          ch_ok;
    logic [CH_W-1:0]               ch_idx;
    logic [DATA_W-1:0]             acc_cur;
    logic [DATA_W-1:0]             add_b;
    logic [DATA_W-1:0]             add_sum;
    logic                          add_carry;

    logic                          out_valid_q;
    logic [DATA_W-1:0]             out_data_q, out_data_d;
    logic                          out_ovf_q, out_ovf_d;
    logic                          out_err_q, out_err_d;
    logic [NUM_CH-1:0][DATA_W-1:0] acc_q, acc_d;
    logic [NUM_CH-1:0]             sticky_q, sticky_d;

    assign op       = op_e'(in_op);
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Out-of-range channels are steered to index 0 only to keep the read legal;
    // ch_ok gates every side effect.
    assign ch_ok   = ({1'b0, in_ch} < NUM_CH_L);
    assign ch_idx  = ch_ok ? in_ch : '0;
    assign acc_cur = acc_q[ch_idx];
    assign add_b   = (op == OP_ACC) ? acc_cur : in_b;

    retro_sat_adder #(.W(DATA_W)) u_adder (
        .a_i      (in_a),
        .b_i      (add_b),
        .sat_en_i (op == OP_ADD_SAT),
        .sum_o    (add_sum),
        .carry_o  (add_carry)
    );

    // Result for the request on the input side, plus accumulator/sticky next state.
    always_comb begin
        out_data_d = '0;
        out_ovf_d  = 1'b0;
        out_err_d  = 1'b0;
        acc_d      = acc_q;
        sticky_d   = clr_sticky ? '0 : sticky_q;
        unique case (op)
            OP_ADD, OP_ADD_SAT: begin
                out_data_d = add_sum;
                out_ovf_d  = add_carry;
            end
            OP_ACC: begin
                if (ch_ok) begin
                    out_data_d = add_sum;
                    out_ovf_d  = add_carry;
                    if (accept) begin
                        acc_d[ch_idx] = add_sum;
                        // A set on this channel beats a same-cycle clear.
                        if (add_carry) sticky_d[ch_idx] = 1'b1;
                    end
                end else begin
                    out_err_d = 1'b1;
                end
            end
            OP_LOAD: begin
                if (ch_ok) begin
                    out_data_d = acc_cur;
                    if (accept) acc_d[ch_idx] = in_a;
                end else begin
                    out_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output holding register (EMPTY/FULL == out_valid_q) and channel state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= out_data_d;
                out_ovf_q   <= out_ovf_d;
                out_err_q   <= out_err_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ovf    = out_ovf_q;
    assign out_err    = out_err_q;
    assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_retro_accum_alu.sv
// Scoreboard bench: drivers push expected results, per-DUT monitors pop on transfer.
module tb_retro_accum_alu;

    typedef struct packed {
        logic [7:0] data;
        logic       ovf;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance (4 channels) and a 3-channel instance for range errors.
    logic       iv4, ir4, ov4, or4, of4, er4, clr4;
    logic [1:0] op4, ch4;
    logic [7:0] a4, b4, od4;
    logic [3:0] st4;
    logic       iv3, ir3, ov3, or3, of3, er3, clr3;
    logic [1:0] op3, ch3;
    logic [7:0] a3, b3, od3;
    logic [2:0] st3;

    retro_accum_alu #(.DATA_W(8), .NUM_CH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_op(op4), .in_ch(ch4),
        .in_a(a4), .in_b(b4), .out_valid(ov4), .out_ready(or4), .out_data(od4),
        .out_ovf(of4), .out_err(er4), .sticky_ovf(st4), .clr_sticky(clr4));

    retro_accum_alu #(.DATA_W(8), .NUM_CH(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_op(op3), .in_ch(ch3),
        .in_a(a3), .in_b(b3), .out_valid(ov3), .out_ready(or3), .out_data(od3),
        .out_ovf(of3), .out_err(er3), .sticky_ovf(st3), .clr_sticky(clr3));

    exp_t q4[$];
    exp_t q3[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic mon_pop(input int sel, input logic [7:0] d, input logic f, input logic e);
        exp_t x;
        if ((sel == 4 && q4.size() == 0) || (sel == 3 && q3.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result dut%0d: got data %0h, no result expected", sel, d);
        end else begin
            x = (sel == 4) ? q4.pop_front() : q3.pop_front();
            chk($sformatf("dut%0d.out_data", sel), 32'(d), 32'(x.data));
            chk($sformatf("dut%0d.out_ovf", sel), 32'(f), 32'(x.ovf));
            chk($sformatf("dut%0d.out_err", sel), 32'(e), 32'(x.err));
        end
    endtask

    always @(negedge clk) if (!rst && ov4 && or4) mon_pop(4, od4, of4, er4);
    always @(negedge clk) if (!rst && ov3 && or3) mon_pop(3, od3, of3, er3);

    // Present one request; returns at posedge+1 after acceptance with in_valid still high.
    task automatic issue(input int sel, input logic [1:0] op, input logic [1:0] ch,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic eo, input logic ee,
                         output int waits);
        exp_t x;
        logic rdy;
        x = '{data: ed, ovf: eo, err: ee};
        if (sel == 4) begin iv4 = 1; op4 = op; ch4 = ch; a4 = a; b4 = b; end
        else          begin iv3 = 1; op3 = op; ch3 = ch; a3 = a; b3 = b; end
        waits = 0;
        forever begin
            @(negedge clk);
            rdy = (sel == 4) ? ir4 : ir3;
            if (rdy) begin
                if (sel == 4) q4.push_back(x); else q3.push_back(x);
                break;
            end
            waits++;
            if (waits > 20) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout dut%0d: in_ready stayed %0d, required 1", sel, rdy);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int sel, input logic [1:0] op, input logic [1:0] ch,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic eo, input logic ee);
        int w;
        issue(sel, op, ch, a, b, ed, eo, ee, w);
    endtask

    task automatic idle_cycle();
        iv4 = 0;
        iv3 = 0;
        @(posedge clk);
        #1;
    endtask

    localparam logic [1:0] ADD = 2'b00, SAT = 2'b01, ACC = 2'b10, LD = 2'b11;

    initial begin
        int w;
        rst = 1;
        {iv4, op4, ch4, a4, b4, or4, clr4} = '0;
        {iv3, op3, ch3, a3, b3, or3, clr3} = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.out_valid", 32'(ov4), 0);
        chk("reset.out_data", 32'(od4), 0);
        chk("reset.ovf_err", 32'({of4, er4}), 0);
        chk("reset.sticky", 32'(st4), 0);
        @(posedge clk);
        #1;
        rst = 0;
        or4 = 1;
        or3 = 1;

        // Build state, then reset with a result pending.
        go(4, ACC, 0, 8'hFF, 0, 8'hFF, 0, 0);
        go(4, ACC, 0, 8'h02, 0, 8'h01, 1, 0);
        go(4, ACC, 1, 8'h33, 0, 8'h33, 0, 0);
        iv4 = 0;
        or4 = 0;
        @(negedge clk);
        chk("pending.out_valid", 32'(ov4), 1);
        chk("pending.sticky", 32'(st4), 32'h1);
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        q4.delete();
        @(negedge clk);
        chk("midreset.out_valid", 32'(ov4), 0);
        chk("midreset.sticky", 32'(st4), 0);
        chk("midreset.in_ready", 32'(ir4), 1);
        @(posedge clk);
        #1;
        or4 = 1;
        go(4, ACC, 0, 8'h00, 0, 8'h00, 0, 0);
        go(4, ACC, 1, 8'h00, 0, 8'h00, 0, 0);

        // Plain and saturating add.
        go(4, ADD, 0, 8'hF0, 8'h20, 8'h10, 1, 0);
        go(4, SAT, 0, 8'hF0, 8'h20, 8'hFF, 1, 0);
        go(4, SAT, 3, 8'h10, 8'h20, 8'h30, 0, 0);

        // Back-to-back accumulate on channel 2, then LOAD returns the old value.
        go(4, ACC, 2, 8'h80, 0, 8'h80, 0, 0);
        go(4, ACC, 2, 8'h80, 0, 8'h00, 1, 0);
        go(4, ACC, 2, 8'h80, 0, 8'h80, 0, 0);
        go(4, LD, 2, 8'h05, 0, 8'h80, 0, 0);
        go(4, ACC, 2, 8'h00, 0, 8'h05, 0, 0);
        idle_cycle();
        @(negedge clk);
        chk("acc.sticky", 32'(st4), 32'h4);
        @(posedge clk);
        #1;

        // Backpressure: three stalled cycles, then full throughput.
        or4 = 0;
        go(4, ADD, 0, 8'h01, 8'h02, 8'h03, 0, 0);
        op4 = ADD; a4 = 8'h03; b4 = 8'h04;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall.in_ready", 32'(ir4), 0);
            chk("stall.out_data", 32'({ov4, od4}), 32'h103);
        end
        @(posedge clk);
        #1;
        or4 = 1;
        issue(4, ADD, 0, 8'h03, 8'h04, 8'h07, 0, 0, w);
        chk("release.waits", 32'(w), 0);
        issue(4, ADD, 0, 8'h10, 8'h10, 8'h20, 0, 0, w);
        chk("tput1.waits", 32'(w), 0);
        issue(4, ADD, 0, 8'hFF, 8'h01, 8'h00, 1, 0, w);
        chk("tput2.waits", 32'(w), 0);
        issue(4, SAT, 0, 8'hFF, 8'h01, 8'hFF, 1, 0, w);
        chk("tput3.waits", 32'(w), 0);

        // Sticky clear coinciding with an overflow on channel 1.
        go(4, LD, 1, 8'hF0, 0, 8'h00, 0, 0);
        clr4 = 1;
        go(4, ACC, 1, 8'h20, 0, 8'h10, 1, 0);
        clr4 = 0;
        idle_cycle();
        @(negedge clk);
        chk("clr_vs_set.sticky", 32'(st4), 32'h2);
        @(posedge clk);
        #1;
        clr4 = 1;
        @(posedge clk);
        #1;
        clr4 = 0;
        @(negedge clk);
        chk("clr_only.sticky", 32'(st4), 0);
        @(posedge clk);
        #1;

        // Out-of-range channel on the 3-channel instance.
        go(3, ACC, 1, 8'h11, 0, 8'h11, 0, 0);
        go(3, ACC, 3, 8'h55, 0, 8'h00, 0, 1);
        go(3, LD, 3, 8'h99, 0, 8'h00, 0, 1);
        go(3, ACC, 1, 8'h00, 0, 8'h11, 0, 0);
        go(3, ADD, 3, 8'h01, 8'h01, 8'h02, 0, 0);
        go(3, ACC, 2, 8'hFF, 0, 8'hFF, 0, 0);
        go(3, LD, 0, 8'h01, 0, 8'h00, 0, 0);
        idle_cycle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("dut3.sticky", 32'(st3), 0);
        chk("drain.q4_left", 32'(q4.size()), 0);
        chk("drain.q3_left", 32'(q3.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
